// File: rtl/interval_event_timer_pkg.sv
// ---------------------------------------------------------------------------
// interval_event_timer_pkg
//   Shared definitions for the interval event timer:
//     - FSM state encoding (IDLE / RUN)
//     - default parameter values for the timer and its prescaler
//     - saturating-increment helper used by the missed-event counter
// ---------------------------------------------------------------------------
package interval_event_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_NBITS     = 32;
    localparam int unsigned DEF_PRESCALE  = 0;
    localparam int unsigned DEF_MISS_BITS = 8;
    localparam int unsigned DEF_SEQ_BITS  = 8;

    // Increment that sticks at max_value instead of wrapping.
    // Operates on 32 bits; callers narrower than that cast in and out.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/interval_event_timer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//   Modulo-(P_PRESCALE+1) counter producing one tick per P_PRESCALE+1
//   enabled clock cycles.
//   Ports:
//     clk    - clock, rising edge
//     reset  - asynchronous active-low reset
//     clr    - synchronous clear of counter and tick (priority over cnten)
//     cnten  - count enable
//     tick   - registered tick, high for one cycle when the counter wraps
//
//   The tick is registered: the cycle in which the counter sits at its
//   maximum produces tick=1 in the following cycle. After a clear the
//   first tick therefore appears P_PRESCALE+1 cycles later, which gives the
//   timer its one-cycle start-up latency.
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int unsigned P_PRESCALE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic cnten,
    output logic tick
);

    // A 0-bit counter is not legal, so a divide-by-1 still carries one bit
    // that simply never leaves zero.
    localparam int unsigned PW = (P_PRESCALE > 0) ? $clog2(P_PRESCALE + 1) : 1;
    localparam logic [PW-1:0] CNT_MAX = PW'(P_PRESCALE);
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    logic [PW-1:0] cnt_reg;
    logic          tick_reg;
    logic          at_max;

    assign at_max = (cnt_reg == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnten) begin
            cnt_reg  <= at_max ? '0 : cnt_reg + CNT_ONE;
            tick_reg <= at_max;
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/interval_event_timer.sv
// ---------------------------------------------------------------------------
// interval_event_timer
//   Programmable interval timer / event source. Counts prescaled ticks up to
//   a latched period and emits an event token on a valid/ready handshake.
//   One-shot or periodic; events that expire while an earlier one is still
//   unconsumed are dropped and counted in a saturating counter.
//   Ports:
//     clk          - clock, rising edge
//     reset        - asynchronous active-low reset
//     cfg_period   - interval length in ticks (0 treated as 1), sampled on start
//     cfg_periodic - 1 = periodic, 0 = one-shot, sampled on start
//     start        - start request, honoured only in IDLE
//     stop         - abort request, outranks start and expire
//     evt_val      - event valid
//     evt_rdy      - consumer ready
//     evt_seq      - sequence number of the presented event
//     busy         - high while running
//     cur_count    - current interval count
//     miss_cnt     - saturating count of dropped events
// ---------------------------------------------------------------------------
module interval_event_timer
    import interval_event_timer_pkg::*;
#(
    parameter int unsigned P_NBITS     = DEF_NBITS,
    parameter int unsigned P_PRESCALE  = DEF_PRESCALE,
    parameter int unsigned P_MISS_BITS = DEF_MISS_BITS,  // at most 32
    parameter int unsigned P_SEQ_BITS  = DEF_SEQ_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [P_NBITS-1:0]     cfg_period,
    input  logic                   cfg_periodic,
    input  logic                   start,
    input  logic                   stop,
    output logic                   evt_val,
    input  logic                   evt_rdy,
    output logic [P_SEQ_BITS-1:0]  evt_seq,
    output logic                   busy,
    output logic [P_NBITS-1:0]     cur_count,
    output logic [P_MISS_BITS-1:0] miss_cnt
);

    localparam logic [P_NBITS-1:0]    CNT_ONE  = P_NBITS'(1);
    localparam logic [P_SEQ_BITS-1:0] SEQ_ONE  = P_SEQ_BITS'(1);
    localparam logic [31:0]           MISS_MAX = 32'((64'd1 << P_MISS_BITS) - 64'd1);

    state_e                   state_reg,    state_next;
    logic [P_NBITS-1:0]       count_reg,    count_next;
    logic [P_NBITS-1:0]       period_reg,   period_next;
    logic                     periodic_reg, periodic_next;
    logic                     evt_val_reg,  evt_val_next;
    logic [P_SEQ_BITS-1:0]    evt_seq_reg,  evt_seq_next;
    logic [P_MISS_BITS-1:0]   miss_reg,     miss_next;
    logic                     busy_reg;

    logic tick;
    logic start_acc;
    logic stop_run;
    logic at_last;
    logic expire;

    assign start_acc = (state_reg == ST_IDLE) && start && !stop;
    assign stop_run  = (state_reg == ST_RUN)  && stop;
    assign at_last   = (count_reg == period_reg - CNT_ONE);
    // stop suppresses the expire entirely: no event and no miss
    assign expire    = (state_reg == ST_RUN) && !stop && tick && at_last;

    tick_prescaler #(
        .P_PRESCALE (P_PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc || stop_run),
        .cnten (state_reg == ST_RUN),
        .tick  (tick)
    );

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        period_next   = period_reg;
        periodic_next = periodic_reg;
        evt_val_next  = evt_val_reg;
        evt_seq_next  = evt_seq_reg;
        miss_next     = miss_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_acc) begin
                    period_next   = (cfg_period == '0) ? CNT_ONE : cfg_period;
                    periodic_next = cfg_periodic;
                    count_next    = '0;
                    miss_next     = '0;
                    state_next    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    count_next = '0;
                    state_next = ST_IDLE;
                end else if (tick) begin
                    if (at_last) begin
                        count_next = '0;
                        if (!periodic_reg) begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        count_next = count_reg + CNT_ONE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Handshake runs regardless of state so a pending event survives stop.
        if (evt_val_reg && evt_rdy) begin
            evt_val_next = 1'b0;
        end

        // A slot is free if nothing is pending or the pending one is being
        // consumed this very cycle; otherwise the new event is dropped.
        if (expire) begin
            if (!evt_val_reg || evt_rdy) begin
                evt_val_next = 1'b1;
                evt_seq_next = evt_seq_reg + SEQ_ONE;
            end else begin
                miss_next = P_MISS_BITS'(sat_inc(32'(miss_reg), MISS_MAX));
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            period_reg   <= CNT_ONE;
            periodic_reg <= 1'b0;
            evt_val_reg  <= 1'b0;
            evt_seq_reg  <= '0;
            miss_reg     <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            period_reg   <= period_next;
            periodic_reg <= periodic_next;
            evt_val_reg  <= evt_val_next;
            evt_seq_reg  <= evt_seq_next;
            miss_reg     <= miss_next;
            busy_reg     <= (state_next == ST_RUN);
        end
    end

    assign evt_val   = evt_val_reg;
    assign evt_seq   = evt_seq_reg;
    assign busy      = busy_reg;
    assign cur_count = count_reg;
    assign miss_cnt  = miss_reg;

endmodule

// File: doc/interval_event_timer.md
Name: interval_event_timer

Overview:
- Programmable interval timer and event source; sits directly downstream of the team's free-running counters.
- Consumes a prescaled tick and counts a latched period, then issues an event token over a valid/ready handshake.
- Supports one-shot and periodic modes.
- Counts events dropped because the consumer stalled.

Parameters:
P_NBITS, 32, width of period register and interval count
P_PRESCALE, 0, prescaler maximum; one tick every P_PRESCALE+1 clk cycles
P_MISS_BITS, 8, width of saturating missed-event counter
P_SEQ_BITS, 8, width of event sequence number

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
cfg_period  input  P_NBITS  interval length in ticks; sampled only when start is accepted
cfg_periodic  input  1  1 = periodic, 0 = one-shot; sampled with cfg_period
start  input  1  start request; accepted only in IDLE
stop  input  1  abort request
evt_val  output  1  event valid
evt_rdy  input  1  consumer ready
evt_seq  output  P_SEQ_BITS  sequence number of presented event
busy  output  1  high while in RUN
cur_count  output  P_NBITS  current interval count
miss_cnt  output  P_MISS_BITS  saturating count of overwritten/dropped events

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - count, prescaler, evt_val, evt_seq, miss_cnt, busy all 0.
  - period_r = 1, periodic_r = 0.
- States: IDLE, RUN. busy = (state == RUN), registered.
- IDLE:
  - start=1 and stop=0 →
    - latch period_r = cfg_period, with cfg_period == 0 forced to 1;
    - latch periodic_r = cfg_periodic;
    - clear count, prescaler and miss_cnt;
    - go to RUN next cycle.
  - start and stop both 1 → stop wins; remain in IDLE.
- RUN, prescaler:
  - Prescaler increments every cycle.
  - tick = (prescaler == P_PRESCALE); on tick the prescaler wraps to 0.
  - With P_PRESCALE = 0, tick is high every cycle.
- RUN, on tick:
  - count == period_r-1 → expire; count returns to 0.
  - Otherwise count increments by 1.
  - No wrap beyond period_r-1.
- Expire:
  - If evt_val=0, or evt_val&&evt_rdy in the same cycle → evt_val=1 and evt_seq increments (modulo 2^P_SEQ_BITS).
  - Otherwise (pending event not consumed) → event dropped: evt_val and evt_seq unchanged; miss_cnt increments, saturating at all-ones.
- After expire:
  - periodic_r=0 → IDLE next cycle.
  - periodic_r=1 → stay in RUN.
- stop in RUN:
  - IDLE next cycle; count and prescaler cleared.
  - stop outranks a simultaneous expire: no event and no miss.
  - A pending evt_val is retained until handshake.
- start in RUN is ignored (no restart, no relatch).
- Handshake:
  - evt_val stays high until evt_val&&evt_rdy, independent of state.
  - evt_seq is stable while evt_val=1.
  - evt_rdy without evt_val has no effect.
- Latency, P_PRESCALE=0, period N:
  - start sampled at edge 0 → busy=1 after edge 0.
  - First evt_val=1 after edge N+1.
  - Periodic repeat every N*(P_PRESCALE+1) cycles.
- cur_count mirrors the count register directly (no extra latency).
- Reset asserted mid-interval aborts everything immediately, including a pending event.

Decomposition:
- Package interval_event_timer_pkg:
  - state encoding (IDLE=1'b0, RUN=1'b1);
  - default width constants;
  - saturating-increment helper function.
- One sub-module: tick_prescaler.
  - Parameterised modulo-(P_PRESCALE+1) counter with clr, cnten, tick output and async active-low reset.
  - Instantiated once; clr driven by start accept or stop.

Test Plan:
- Reset, then start with cfg_period=4, one-shot, evt_rdy=1, P_PRESCALE=0 → evt_val pulses once 5 cycles after start, evt_seq=1, busy drops next cycle, cur_count=0.
- Periodic, cfg_period=3, evt_rdy=1 → events every 3 cycles; evt_seq 1,2,3,4; miss_cnt stays 0.
- Periodic, cfg_period=2, evt_rdy=0 for 7 cycles → evt_val held with evt_seq=1; miss_cnt=2 (expiries at cycles 4 and 6 dropped); raise evt_rdy → handshake completes, evt_seq=1 observed once.
- Consume and expire in the same cycle (periodic, period 1, evt_rdy=1) → evt_val stays high continuously, evt_seq increments every cycle, miss_cnt=0.
- stop on the exact expire cycle, and start+stop together in IDLE → no event emitted, busy=0 next cycle; second case stays IDLE with period_r unchanged.
- cfg_period=0 start, then async reset asserted mid-RUN between clock edges → behaves as period 1; on reset all outputs go to 0 immediately, without waiting for clk.
